core_host_ctrl: RTL and testbench

//  Host-side control block for the RV32I core: byte-serial program loader, run/halt/single-step

---
 rtl/core_host_pkg.sv | 25 ++
 rtl/core_host_ctrl_ser.sv | 89 ++++++++
 rtl/core_host_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_core_host_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_host_pkg.sv
// Package: core_host_pkg
// Shared definitions for the host control block: host command byte codes and
// the command FSM state encoding.
package core_host_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'

  typedef enum logic [3:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    RUN,
    STEP,
    DUMP_LATCH,
    DUMP_SEND,
    DUMP_WAIT,
    CSUM
  } state_e;

endpackage

// File: rtl/core_host_ctrl_ser.sv
// Module: host_tx_serializer
// Sends a word LSB-first as XLEN/8 bytes (or only its low byte when one_byte
// is set at start) over a UART TX byte interface, then pulses done.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, one_byte   load word and begin sending (ignored while active)
//   word              word to send
//   tx_byte, tx_valid byte and one-cycle send strobe to the UART
//   tx_busy           UART busy; only consulted two cycles after a strobe
//   done              one-cycle pulse once the last byte has been sent
module host_tx_serializer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            one_byte,
  input  logic [XLEN-1:0] word,
  output logic [7:0]      tx_byte,
  output logic            tx_valid,
  input  logic            tx_busy,
  output logic            done
);

  localparam int BPW = XLEN / 8;
  localparam int CW  = $clog2(BPW + 1);

  logic            active_q, active_d;
  logic [CW-1:0]   left_q, left_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_valid_q, tx_valid_d;
  logic            lag_q, lag_d;
  logic            done_q, done_d;

  always_comb begin
    active_d   = active_q;
    left_d     = left_q;
    shreg_d    = shreg_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    // The UART raises busy one cycle late, so the cycle after a strobe is
    // treated as busy regardless of tx_busy.
    lag_d      = tx_valid_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        shreg_d  = word;
        left_d   = one_byte ? CW'(1) : CW'(BPW);
      end
    end else if (left_q == '0) begin
      if (!tx_valid_q && !lag_q) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end else if (!tx_valid_q && !lag_q && !tx_busy) begin
      tx_valid_d = 1'b1;
      tx_byte_d  = shreg_q[7:0];
      shreg_d    = shreg_q >> 8;
      left_d     = left_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= 1'b0;
      left_q     <= '0;
      shreg_q    <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      lag_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      active_q   <= active_d;
      left_q     <= left_d;
      shreg_q    <= shreg_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      lag_q      <= lag_d;
      done_q     <= done_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;

endmodule

// File: rtl/core_host_ctrl.sv
// Module: core_host_ctrl
// Host-side control for the RV32I core: byte-serial imem loader, run/halt/step
// gating of the core clock enable, and register-file dump over UART bytes.
// Optional build macro: CORE_HOST_CHECKSUM_EN appends an XOR checksum byte to
// every dump.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   rx_byte, rx_valid    host byte and its one-cycle strobe
//   imem_we/waddr/wdata  imem write port (one-cycle write strobe)
//   core_en              core pc/regfile update enable
//   reg_raddr, reg_rdata regfile debug read port (combinational data)
//   tx_byte, tx_valid    byte to UART TX and its one-cycle strobe
//   tx_busy              UART TX busy
//   halted               high while the command FSM is idle
//
// state      | meaning
// IDLE       | halted, waiting for a command byte
// CNT_LO     | waiting for word count low byte
// CNT_HI     | waiting for word count high byte
// DATA       | assembling instruction words LSB first
// RUN        | core enabled until 'H'
// STEP       | core enabled for this single cycle
// DUMP_LATCH | reg_raddr presented, capture read data
// DUMP_SEND  | start serializer on captured word
// DUMP_WAIT  | wait for serializer done
// CSUM       | start serializer on checksum byte
module core_host_ctrl
  import core_host_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int RF_AW    = 5,
  parameter int IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               core_en,
  output logic [RF_AW-1:0]   reg_raddr,
  input  logic [XLEN-1:0]    reg_rdata,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_busy,
  output logic               halted
);

  localparam int BPW = XLEN / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  state_e             state_q, state_d;
  logic [7:0]         cnt_lo_q, cnt_lo_d;
  logic [15:0]        words_left_q, words_left_d;
  logic [BIW-1:0]     byte_idx_q, byte_idx_d;
  logic [XLEN-1:0]    word_q, word_d;
  logic [IMEM_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_waddr_q, imem_waddr_d;
  logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;
  logic               core_en_q, core_en_d;
  logic [RF_AW-1:0]   reg_raddr_q, reg_raddr_d;
  logic [XLEN-1:0]    dump_word_q, dump_word_d;
  logic               halted_q, halted_d;

  logic               ser_start, ser_one_byte, ser_done;
  logic [XLEN-1:0]    ser_word;

`ifdef CORE_HOST_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_phase_q, csum_phase_d;

  function automatic logic [7:0] xor_fold(input logic [XLEN-1:0] w);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < BPW; i++) acc ^= w[8*i +: 8];
    return acc;
  endfunction

  assign ser_start    = (state_q == DUMP_SEND) || (state_q == CSUM);
  assign ser_one_byte = (state_q == CSUM);
  assign ser_word     = (state_q == CSUM) ? XLEN'(csum_q) : dump_word_q;
`else
  assign ser_start    = (state_q == DUMP_SEND);
  assign ser_one_byte = 1'b0;
  assign ser_word     = dump_word_q;
`endif

  host_tx_serializer #(.XLEN(XLEN)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .start    (ser_start),
    .one_byte (ser_one_byte),
    .word     (ser_word),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_busy  (tx_busy),
    .done     (ser_done)
  );

  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    wr_ptr_d     = wr_ptr_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    core_en_d    = 1'b0;
    reg_raddr_d  = reg_raddr_q;
    dump_word_d  = dump_word_q;
`ifdef CORE_HOST_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            CMD_LOAD: begin
              state_d    = CNT_LO;
              wr_ptr_d   = '0;
              byte_idx_d = '0;
            end
            CMD_RUN: begin
              state_d   = RUN;
              core_en_d = 1'b1;
            end
            CMD_STEP: begin
              state_d   = STEP;
              core_en_d = 1'b1;
            end
            CMD_DUMP: begin
              state_d     = DUMP_LATCH;
              reg_raddr_d = '0;
`ifdef CORE_HOST_CHECKSUM_EN
              csum_d       = '0;
              csum_phase_d = 1'b0;
`endif
            end
            default: ;
          endcase
        end
      end
      CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_d = rx_byte;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_valid) begin
          words_left_d = {rx_byte, cnt_lo_q};
          state_d      = ({rx_byte, cnt_lo_q} == 16'd0) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          // New byte enters at the top, so after BPW bytes the first one is the LSB.
          word_d     = (word_q >> 8) | (XLEN'(rx_byte) << (XLEN - 8));
          byte_idx_d = byte_idx_q + BIW'(1);
          if (byte_idx_q == BIW'(BPW - 1)) begin
            byte_idx_d   = '0;
            imem_we_d    = 1'b1;
            imem_waddr_d = wr_ptr_q;
            imem_wdata_d = word_d;
            wr_ptr_d     = wr_ptr_q + IMEM_AW'(1);
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) state_d = IDLE;
          end
        end
      end
      RUN: begin
        if (rx_valid && rx_byte == CMD_HALT) state_d = IDLE;
        else core_en_d = 1'b1;
      end
      STEP: state_d = IDLE;
      DUMP_LATCH: begin
        dump_word_d = reg_rdata;
`ifdef CORE_HOST_CHECKSUM_EN
        csum_d = csum_q ^ xor_fold(reg_rdata);
`endif
        state_d = DUMP_SEND;
      end
      DUMP_SEND: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        if (ser_done) begin
`ifdef CORE_HOST_CHECKSUM_EN
          if (csum_phase_q) state_d = IDLE;
          else
`endif
          if (reg_raddr_q == RF_AW'(NUM_REGS - 1)) begin
`ifdef CORE_HOST_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
`endif
          end else begin
            reg_raddr_d = reg_raddr_q + RF_AW'(1);
            state_d     = DUMP_LATCH;
          end
        end
      end
`ifdef CORE_HOST_CHECKSUM_EN
      CSUM: begin
        csum_phase_d = 1'b1;
        state_d      = DUMP_WAIT;
      end
`endif
      default: state_d = IDLE;
    endcase
    halted_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      wr_ptr_q     <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      core_en_q    <= 1'b0;
      reg_raddr_q  <= '0;
      dump_word_q  <= '0;
      halted_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      wr_ptr_q     <= wr_ptr_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      core_en_q    <= core_en_d;
      reg_raddr_q  <= reg_raddr_d;
      dump_word_q  <= dump_word_d;
      halted_q     <= halted_d;
    end
  end

`ifdef CORE_HOST_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
    end else begin
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
    end
  end
`endif

  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_en    = core_en_q;
  assign reg_raddr  = reg_raddr_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_core_host_ctrl.sv
module tb_core_host_ctrl;

  localparam int AW = 2;
  localparam logic [7:0] B_L = 8'h4C, B_R = 8'h52, B_S = 8'h53, B_H = 8'h48, B_D = 8'h44;
`ifdef CORE_HOST_CHECKSUM_EN
  localparam int DUMP_LEN = 129;
`else
  localparam int DUMP_LEN = 128;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_en;
  logic [4:0]    reg_raddr;
  logic [31:0]   reg_rdata;
  logic [7:0]    tx_byte;
  logic          tx_valid;
  logic          tx_busy;
  logic          halted;

  always #5 clk = ~clk;

  core_host_ctrl #(.XLEN(32), .NUM_REGS(32), .RF_AW(5), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_en(core_en), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_busy(tx_busy), .halted(halted)
  );

  logic [31:0] regs [32];
  assign reg_rdata = regs[reg_raddr];

  int pass_cnt = 0, chk_cnt = 0;
  int cyc = 0;
  int strobe_cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // observed behaviour
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  logic [7:0]  tx_q[$];
  int en_cnt, en_first, viol, busy_hold = 0, busy_left = 0;
  // expectations from the reference model
  logic [31:0] exp_addr[$], exp_data[$];
  logic [7:0]  exp_tx[$], stim[$];

  typedef struct {
    string      name;
    logic [7:0] cmd;
    int         gap;
    int         exp_en;
  } vec_t;
  vec_t vecs[7];

  // Monitor plus UART busy model: busy follows each strobe for busy_hold cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        wr_addr_q.push_back(32'(imem_waddr));
        wr_data_q.push_back(imem_wdata);
      end
      if (core_en === 1'b1) begin
        if (en_cnt == 0) en_first = cyc;
        en_cnt++;
      end
      if (tx_valid === 1'b1) begin
        if (tx_busy) viol++;
        tx_q.push_back(tx_byte);
        busy_left = busy_hold;
      end else if (busy_left > 0) busy_left--;
      tx_busy = (busy_left > 0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1; strobe_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
    exp_addr.delete(); exp_data.delete(); exp_tx.delete();
    en_cnt = 0; viol = 0;
  endtask

  // Sends 'L', the count and the stim bytes; expected words come straight
  // from the byte stream: word w is bytes 4w..4w+3, little-endian, at w mod 2**AW.
  task automatic load_send(input logic [15:0] n);
    send_byte(B_L); send_byte(n[7:0]); send_byte(n[15:8]);
    for (int i = 0; i < 4 * int'(n); i++) send_byte(stim[i]);
    for (int w = 0; w < int'(n); w++) begin
      exp_addr.push_back(32'(w % (1 << AW)));
      exp_data.push_back(32'(stim[4*w]) + (32'(stim[4*w+1]) << 8) +
                         (32'(stim[4*w+2]) << 16) + (32'(stim[4*w+3]) << 24));
    end
  endtask

  task automatic load_check(input string tag);
    idle(4);
    check({tag, " write count"}, wr_data_q.size(), exp_data.size());
    for (int i = 0; i < wr_data_q.size() && i < exp_data.size(); i++) begin
      check($sformatf("%s wr%0d addr", tag, i), wr_addr_q[i], exp_addr[i]);
      check($sformatf("%s wr%0d data", tag, i), wr_data_q[i], exp_data[i]);
    end
    check({tag, " halted"}, 32'(halted), 32'd1);
    check({tag, " core_en cycles"}, en_cnt, 0);
  endtask

  task automatic run_dump(input string tag, input int hold);
    logic [7:0] x;
    int lim;
    clear_mon();
    busy_hold = hold;
    x = 8'h00;
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++) begin
        exp_tx.push_back(regs[r][8*b +: 8]);
        x ^= regs[r][8*b +: 8];
      end
`ifdef CORE_HOST_CHECKSUM_EN
    exp_tx.push_back(x);
`endif
    send_byte(B_D);
    send_byte(B_S);
    send_byte(B_L);
    for (lim = 0; lim < 6000 && tx_q.size() < exp_tx.size(); lim++) idle(1);
    idle(40);
    check({tag, " byte count"}, tx_q.size(), DUMP_LEN);
    for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));
    check({tag, " core_en cycles"}, en_cnt, 0);
    check({tag, " strobe while busy"}, viol, 0);
    check({tag, " imem writes"}, wr_data_q.size(), 0);
    check({tag, " halted"}, 32'(halted), 32'd1);
  endtask

  task automatic run_seq(input string tag, input int k);
    int r_cyc;
    logic [7:0] junk;
    clear_mon();
    send_byte(B_R);
    r_cyc = strobe_cyc;
    for (int j = 0; j < k; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        if (junk == B_H) junk = 8'h00;
        send_byte(junk);
      end else idle(1);
    end
    check({tag, " halted in run"}, 32'(halted), 32'd0);
    send_byte(B_H);
    idle(5);
    check({tag, " core_en cycles"}, en_cnt, strobe_cyc - r_cyc);
    check({tag, " core_en first"}, en_first, r_cyc + 1);
    check({tag, " halted after"}, 32'(halted), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    vecs[0] = '{"step",      B_S,   0, 1};
    vecs[1] = '{"run_h0",    B_R,   0, 1};
    vecs[2] = '{"run_20",    B_R,  20, 21};
    vecs[3] = '{"run_7",     B_R,   7, 8};
    vecs[4] = '{"unknown_A", 8'h41, 0, 0};
    vecs[5] = '{"halt_idle", B_H,   0, 0};
    vecs[6] = '{"lower_r",   8'h72, 0, 0};

    // reset and idle
    clear_mon();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    check("rst halted", 32'(halted), 32'd1);
    check("rst core_en", 32'(core_en), 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst imem_we", 32'(imem_we), 32'd0);
    check("rst imem_waddr", 32'(imem_waddr), 32'd0);
    check("rst imem_wdata", imem_wdata, 32'd0);
    check("rst reg_raddr", 32'(reg_raddr), 32'd0);
    check("rst tx_byte", 32'(tx_byte), 32'd0);
    check("rst activity", en_cnt + tx_q.size() + wr_data_q.size(), 0);

    // fixed two-word load
    clear_mon();
    stim = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    load_send(16'd2);
    load_check("load2");
    if (wr_data_q.size() == 2) begin
      check("load2 word0 literal", wr_data_q[0], 32'h0010_0513);
      check("load2 word1 literal", wr_data_q[1], 32'h0020_0593);
    end

    // five words wrap the 2-bit address
    clear_mon();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
    load_send(16'd5);
    load_check("load5 wrap");
    if (wr_addr_q.size() == 5) check("load5 5th addr", wr_addr_q[4], 32'd0);

    // N=0 returns to IDLE at once: an immediate 'S' is accepted
    clear_mon();
    load_send(16'd0);
    send_byte(B_S);
    idle(4);
    check("load0 writes", wr_data_q.size(), 0);
    check("load0 then step", en_cnt, 1);

    // table-driven run/step/ignored-byte vectors
    foreach (vecs[v]) begin
      int s;
      clear_mon();
      send_byte(vecs[v].cmd);
      s = strobe_cyc;
      if (vecs[v].cmd == B_R) begin
        idle(vecs[v].gap);
        check({vecs[v].name, " core_en mid"}, 32'(core_en), 32'd1);
        check({vecs[v].name, " halted mid"}, 32'(halted), 32'd0);
        send_byte(B_H);
      end
      idle(5);
      check({vecs[v].name, " core_en cycles"}, en_cnt, vecs[v].exp_en);
      if (vecs[v].exp_en > 0) check({vecs[v].name, " core_en first"}, en_first, s + 1);
      check({vecs[v].name, " halted"}, 32'(halted), 32'd1);
      check({vecs[v].name, " core_en end"}, 32'(core_en), 32'd0);
    end

    // dump with a slow UART
    regs[1] = 32'hDEAD_BEEF;
    run_dump("dump_busy3", 3);
    if (tx_q.size() >= 8) begin
      check("dump x1 b0", 32'(tx_q[4]), 32'hEF);
      check("dump x1 b1", 32'(tx_q[5]), 32'hBE);
      check("dump x1 b2", 32'(tx_q[6]), 32'hAD);
      check("dump x1 b3", 32'(tx_q[7]), 32'hDE);
    end
`ifdef CORE_HOST_CHECKSUM_EN
    if (tx_q.size() == 129) begin
      logic [7:0] xs;
      xs = 8'h00;
      for (int i = 0; i < 128; i++) xs ^= tx_q[i];
      check("dump checksum of sent", 32'(tx_q[128]), 32'(xs));
    end
`endif

    // reset mid-load discards the partial word
    clear_mon();
    send_byte(B_L); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    check("midload rst writes", wr_data_q.size(), 0);
    check("midload rst halted", 32'(halted), 32'd1);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_send(16'd1);
    load_check("reload1");
    if (wr_data_q.size() == 1) check("reload1 literal", wr_data_q[0], 32'h4433_2211);

    // reset mid-run and mid-dump
    clear_mon();
    send_byte(B_R);
    idle(3);
    do_reset();
    check("midrun rst core_en", 32'(core_en), 32'd0);
    check("midrun rst halted", 32'(halted), 32'd1);
    send_byte(B_D);
    idle(30);
    do_reset();
    clear_mon();
    idle(20);
    check("middump rst tx bytes", tx_q.size(), 0);
    check("middump rst raddr", 32'(reg_raddr), 32'd0);
    check("middump rst halted", 32'(halted), 32'd1);

    // randomized operations against the reference model
    for (int it = 0; it < 10; it++) begin
      int op;
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          int n;
          clear_mon();
          n = $urandom_range(0, 6);
          stim.delete();
          for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
          load_send(16'(n));
          load_check($sformatf("rnd%0d load%0d", it, n));
        end
        1: run_seq($sformatf("rnd%0d run", it), $urandom_range(0, 12));
        2: begin
          clear_mon();
          send_byte(B_S);
          idle(4);
          check($sformatf("rnd%0d step cycles", it), en_cnt, 1);
        end
        3: begin
          for (int i = 0; i < 32; i++) regs[i] = $urandom;
          run_dump($sformatf("rnd%0d dump", it), $urandom_range(0, 4));
        end
        default: begin
          logic [7:0] junk;
          clear_mon();
          do junk = 8'($urandom);
          while (junk == B_L || junk == B_R || junk == B_S || junk == B_D);
          send_byte(junk);
          idle(5);
          check($sformatf("rnd%0d junk activity", it), en_cnt + tx_q.size() + wr_data_q.size(), 0);
          check($sformatf("rnd%0d junk halted", it), 32'(halted), 32'd1);
        end
      endcase
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
